// File: rtl/amds_pkg.sv
// amds_pkg: shared constants for the AMDS trigger controller.
// Holds the FSM state encoding, the status-counter width and the receiver count.
package amds_pkg;

    localparam int AMDS_CNT_W = 16;
    localparam int AMDS_N_RX  = 2;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SYNC_HIGH  = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

endpackage

// File: rtl/amds_trigger_ctrl_cnt.sv
// amds_wrap_counter: free-running wrap-around event counter.
// Ports: clk, rst (sync, active high), inc (count enable), count (value).
module amds_wrap_counter
    import amds_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [AMDS_CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/amds_trigger_ctrl.sv
// amds_trigger_ctrl: sequencer driving sync_adc / start_rx for the AMDS receivers.
// Ports: clk, rst, enable, trigger, done0/done1 in; sync_adc, start_rx, busy,
// sample_done, timed_out and three 16-bit status counters out (all registered).
module amds_trigger_ctrl
    import amds_pkg::*;
#(
    parameter int SYNC_HIGH_CYCLES = 100,
    parameter int RX_DELAY_CYCLES  = 0,
    parameter int TIMEOUT_CYCLES   = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  trigger,
    input  logic                  done0,
    input  logic                  done1,
    output logic                  sync_adc,
    output logic                  start_rx,
    output logic                  busy,
    output logic                  sample_done,
    output logic                  timed_out,
    output logic [AMDS_CNT_W-1:0] count_trigger,
    output logic [AMDS_CNT_W-1:0] count_missed,
    output logic [AMDS_CNT_W-1:0] count_timeout
);

    localparam logic [AMDS_CNT_W-1:0] SH_LAST = AMDS_CNT_W'(SYNC_HIGH_CYCLES - 1);
    localparam logic [AMDS_CNT_W-1:0] RX_AT   = AMDS_CNT_W'(RX_DELAY_CYCLES);
    localparam logic [AMDS_CNT_W-1:0] TO_LAST = AMDS_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AMDS_CNT_W-1:0] DONE_OK = AMDS_CNT_W'(2);
    localparam bit RX_IN_SYNC = (RX_DELAY_CYCLES < SYNC_HIGH_CYCLES);

    logic [1:0]            state, state_nx;
    logic [AMDS_CNT_W-1:0] phase;
    logic [AMDS_CNT_W-1:0] wdog;
    logic                  started;
    logic [AMDS_N_RX-1:0]  done_v;
    logic                  all_done;
    logic                  accept, miss, start_c, end_c, to_c;

    assign done_v   = {done1, done0};
    assign all_done = &done_v;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        start_c  = 1'b0;
        end_c    = 1'b0;
        to_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                // busy still reflects the cycle sample_done is shown, so
                // a trigger in that cycle is counted as missed.
                if (trigger && enable && !busy) begin
                    accept   = 1'b1;
                    state_nx = ST_SYNC_HIGH;
                end
            end
            ST_SYNC_HIGH: begin
                start_c = RX_IN_SYNC && (phase == RX_AT);
                if (phase == SH_LAST) begin
                    state_nx = (started || start_c) ? ST_WAIT_DONE : ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                start_c = (phase == RX_AT);
                if (start_c) begin
                    state_nx = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Watchdog 0/1 are the start_rx cycle and the stale-done cycle.
                if ((wdog >= DONE_OK) && all_done) begin
                    end_c = 1'b1;
                end else if (wdog >= TO_LAST) begin
                    end_c = 1'b1;
                    to_c  = 1'b1;
                end
                if (end_c) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        miss = trigger && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= '0;
            wdog        <= '0;
            started     <= 1'b0;
            sync_adc    <= 1'b0;
            start_rx    <= 1'b0;
            busy        <= 1'b0;
            sample_done <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            state       <= state_nx;
            sync_adc    <= (state == ST_SYNC_HIGH);
            start_rx    <= start_c;
            busy        <= (state != ST_IDLE);
            sample_done <= end_c;
            if (accept) begin
                phase <= '0;
            end else if (phase != '1) begin
                phase <= phase + 1'b1;
            end
            if (accept) begin
                started <= 1'b0;
            end else if (start_c) begin
                started <= 1'b1;
            end
            if (start_c) begin
                wdog <= '0;
            end else if (wdog != '1) begin
                wdog <= wdog + 1'b1;
            end
            if (accept) begin
                timed_out <= 1'b0;
            end else if (to_c) begin
                timed_out <= 1'b1;
            end
        end
    end

    amds_wrap_counter u_cnt_trig (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (count_trigger)
    );

    amds_wrap_counter u_cnt_miss (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss),
        .count (count_missed)
    );

    amds_wrap_counter u_cnt_to (
        .clk   (clk),
        .rst   (rst),
        .inc   (to_c),
        .count (count_timeout)
    );

endmodule

// File: tb/tb_amds_trigger_ctrl.sv
// tb_amds_trigger_ctrl: two controller instances (RX delay 0 and 6) under
// shared stimulus, checked every cycle against a timeline model.
module tb_amds_trigger_ctrl;

    localparam int TO = 50;

    int p_sh [2] = '{4, 4};
    int p_dl [2] = '{0, 6};

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic enable  = 1'b0;
    logic trigger = 1'b0;
    logic [1:0] d0 = 2'b11;
    logic [1:0] d1 = 2'b11;
    logic [1:0] sync_v, start_v, busy_v, sd_v, to_v;
    logic [1:0][15:0] ct, cm, cto;

    amds_trigger_ctrl #(
        .SYNC_HIGH_CYCLES(4), .RX_DELAY_CYCLES(0), .TIMEOUT_CYCLES(TO)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
        .done0(d0[0]), .done1(d1[0]),
        .sync_adc(sync_v[0]), .start_rx(start_v[0]), .busy(busy_v[0]),
        .sample_done(sd_v[0]), .timed_out(to_v[0]),
        .count_trigger(ct[0]), .count_missed(cm[0]), .count_timeout(cto[0])
    );

    amds_trigger_ctrl #(
        .SYNC_HIGH_CYCLES(4), .RX_DELAY_CYCLES(6), .TIMEOUT_CYCLES(TO)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
        .done0(d0[1]), .done1(d1[1]),
        .sync_adc(sync_v[1]), .start_rx(start_v[1]), .busy(busy_v[1]),
        .sample_done(sd_v[1]), .timed_out(to_v[1]),
        .count_trigger(ct[1]), .count_missed(cm[1]), .count_timeout(cto[1])
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    // sequence timeline model: accept cycle tc, end cycle e (internal)
    bit m_valid [2];
    bit m_ended [2];
    int m_tc [2];
    int m_e [2];
    logic [15:0] e_trig [2];
    logic [15:0] e_miss [2];
    logic [15:0] e_tout [2];
    bit e_tflag [2];

    // receiver model
    int lat0 = 10;
    int lat1 = 10;
    int c0 [2];
    int c1 [2];
    bit seen [2];

    // measurements
    int n_sync [2], n_start [2], n_sd [2];
    int t_rise [2], t_fall [2], t_start [2], t_sd [2];
    bit p_sync [2];

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic string nm(string s, int i);
        return $sformatf("%s[%0d]@%0d", s, i, cyc);
    endfunction

    task automatic compare(int i);
        int k, t;
        bit es, est, esd, eb;
        k   = cyc;
        t   = m_tc[i] + 2 + p_dl[i];
        es  = m_valid[i] && k >= m_tc[i] + 2 && k <= m_tc[i] + 1 + p_sh[i];
        est = m_valid[i] && k == t;
        esd = m_valid[i] && m_ended[i] && k == m_e[i] + 1;
        eb  = m_valid[i] && k >= m_tc[i] + 2 && (!m_ended[i] || k <= m_e[i] + 1);
        chk(nm("sync_adc", i), int'(sync_v[i]), int'(es));
        chk(nm("start_rx", i), int'(start_v[i]), int'(est));
        chk(nm("sample_done", i), int'(sd_v[i]), int'(esd));
        chk(nm("busy", i), int'(busy_v[i]), int'(eb));
        chk(nm("timed_out", i), int'(to_v[i]), int'(e_tflag[i]));
        chk(nm("count_trigger", i), int'(ct[i]), int'(e_trig[i]));
        chk(nm("count_missed", i), int'(cm[i]), int'(e_miss[i]));
        chk(nm("count_timeout", i), int'(cto[i]), int'(e_tout[i]));
    endtask

    task automatic model_step(int i);
        int k, t, wds;
        k = cyc;
        if (rst) begin
            m_valid[i] = 0;
            m_ended[i] = 0;
            e_trig[i]  = '0;
            e_miss[i]  = '0;
            e_tout[i]  = '0;
            e_tflag[i] = 0;
            return;
        end
        t   = m_tc[i] + 2 + p_dl[i];
        wds = m_tc[i] + 1 + ((p_sh[i] > p_dl[i] + 1) ? p_sh[i] : p_dl[i] + 1);
        if (m_valid[i] && !m_ended[i] && k >= wds) begin
            if (k >= t + 2 && d0[i] && d1[i]) begin
                m_ended[i] = 1;
                m_e[i] = k;
            end else if (k >= t + TO - 1) begin
                m_ended[i] = 1;
                m_e[i] = k;
                e_tout[i] = e_tout[i] + 1'b1;
                e_tflag[i] = 1;
            end
        end
        if (trigger) begin
            if (enable && (!m_valid[i] || (m_ended[i] && k >= m_e[i] + 2))) begin
                m_valid[i] = 1;
                m_ended[i] = 0;
                m_tc[i] = k;
                e_trig[i] = e_trig[i] + 1'b1;
                e_tflag[i] = 0;
            end else begin
                e_miss[i] = e_miss[i] + 1'b1;
            end
        end
    endtask

    task automatic measure(int i);
        if (sync_v[i] && !p_sync[i]) t_rise[i] = cyc;
        if (!sync_v[i] && p_sync[i]) t_fall[i] = cyc;
        if (sync_v[i]) n_sync[i]++;
        if (start_v[i]) begin
            n_start[i]++;
            t_start[i] = cyc;
        end
        if (sd_v[i]) begin
            n_sd[i]++;
            t_sd[i] = cyc;
        end
        p_sync[i] = sync_v[i];
    endtask

    task automatic clr_meas();
        for (int i = 0; i < 2; i++) begin
            n_sync[i] = 0; n_start[i] = 0; n_sd[i] = 0;
            t_rise[i] = -1; t_fall[i] = -1; t_start[i] = -1; t_sd[i] = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (chk_en) compare(i);
            measure(i);
            model_step(i);
            seen[i] = start_v[i] && !rst;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (seen[i]) begin
                d0[i] = 1'b0; d1[i] = 1'b0;
                c0[i] = lat0; c1[i] = lat1;
            end else begin
                if (c0[i] > 0) begin
                    c0[i]--;
                    if (c0[i] == 0) d0[i] = 1'b1;
                end
                if (c1[i] > 0) begin
                    c1[i]--;
                    if (c1[i] == 0) d1[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic fire();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i] && !(m_ended[i] && cyc >= m_e[i] + 2)) return 0;
        end
        return 1;
    endfunction

    task automatic wait_idle(string tag);
        int n = 0;
        while (!all_idle() && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk({tag, " wait_idle"}, 0, 1);
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_ended[i] = 0; m_tc[i] = 0; m_e[i] = 0;
            e_trig[i] = '0; e_miss[i] = '0; e_tout[i] = '0; e_tflag[i] = 0;
            c0[i] = 0; c1[i] = 0; seen[i] = 0; p_sync[i] = 0;
        end
        clr_meas();
        repeat (3) tick();
        chk_en = 1;
        for (int i = 0; i < 2; i++) begin
            chk(nm("rst sync_adc", i), int'(sync_v[i]), 0);
            chk(nm("rst busy", i), int'(busy_v[i]), 0);
            chk(nm("rst count_trigger", i), int'(ct[i]), 0);
        end
        rst = 1'b0;
        enable = 1'b1;
        tick();
        tick();

        // nominal (inst 0) and delayed start (inst 1)
        clr_meas();
        fire();
        wait_idle("nominal");
        for (int i = 0; i < 2; i++) begin
            chk(nm("nom sync_width", i), n_sync[i], 4);
            chk(nm("nom start_count", i), n_start[i], 1);
            chk(nm("nom done_count", i), n_sd[i], 1);
            chk(nm("nom count_trigger", i), int'(ct[i]), 1);
            chk(nm("nom timed_out", i), int'(to_v[i]), 0);
        end
        chk(nm("nom start_after_rise", 0), t_start[0] - t_rise[0], 0);
        chk(nm("dly start_after_rise", 1), t_start[1] - t_rise[1], 6);
        chk(nm("dly start_after_fall", 1), t_start[1] - t_fall[1], 2);

        // watchdog expiry, then a good sequence clears timed_out
        lat1 = -1;
        clr_meas();
        fire();
        wait_idle("timeout");
        for (int i = 0; i < 2; i++) begin
            chk(nm("to done_after_start", i), t_sd[i] - t_start[i], 50);
            chk(nm("to timed_out", i), int'(to_v[i]), 1);
            chk(nm("to count_timeout", i), int'(cto[i]), 1);
        end
        lat1 = 10;
        clr_meas();
        fire();
        wait_idle("recover");
        for (int i = 0; i < 2; i++) begin
            chk(nm("rec timed_out", i), int'(to_v[i]), 0);
            chk(nm("rec count_trigger", i), int'(ct[i]), 3);
        end

        // dropped triggers: 3 while busy, 2 while disabled
        clr_meas();
        fire();
        tick();
        tick();
        repeat (3) begin
            fire();
            tick();
        end
        wait_idle("drop");
        enable = 1'b0;
        repeat (2) begin
            fire();
            tick();
        end
        enable = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk(nm("drop count_missed", i), int'(cm[i]), 5);
            chk(nm("drop count_trigger", i), int'(ct[i]), 4);
            chk(nm("drop start_count", i), n_start[i], 1);
        end

        // done and watchdog expiry on the same cycle
        lat0 = 48;
        lat1 = 48;
        clr_meas();
        fire();
        wait_idle("collide");
        for (int i = 0; i < 2; i++) begin
            chk(nm("col done_count", i), n_sd[i], 1);
            chk(nm("col done_after_start", i), t_sd[i] - t_start[i], 50);
            chk(nm("col timed_out", i), int'(to_v[i]), 0);
            chk(nm("col count_timeout", i), int'(cto[i]), 1);
        end

        // reset while waiting for done
        lat0 = 30;
        lat1 = 30;
        clr_meas();
        fire();
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = 2'b11;
        d1 = 2'b11;
        for (int i = 0; i < 2; i++) begin
            c0[i] = 0; c1[i] = 0;
        end
        repeat (40) tick();
        for (int i = 0; i < 2; i++) begin
            chk(nm("rst done_count", i), n_sd[i], 0);
            chk(nm("rst count_trigger", i), int'(ct[i]), 0);
            chk(nm("rst sync_low", i), int'(sync_v[i]), 0);
        end

        // trigger counter wrap
        force dut_a.u_cnt_trig.count = 16'hFFFF;
        force dut_b.u_cnt_trig.count = 16'hFFFF;
        e_trig[0] = 16'hFFFF;
        e_trig[1] = 16'hFFFF;
        tick();
        release dut_a.u_cnt_trig.count;
        release dut_b.u_cnt_trig.count;
        tick();
        fire();
        wait_idle("wrap");
        for (int i = 0; i < 2; i++) begin
            chk(nm("wrap count_trigger", i), int'(ct[i]), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amds_trigger_ctrl.md
# amds_trigger_ctrl

Upstream sequencer for the AMDS serial ADC receive path. On each accepted trigger it drives the AMDS `sync_adc` pin, issues a one-cycle `start_rx` to both per-data-line `adc_uart_rx` receivers, then waits until both report done or a watchdog expires. It produces a one-cycle `sample_done` strobe and status counters for the register interface.

## Interface
- `SYNC_HIGH_CYCLES`, 100: cycles `sync_adc` is held high; range 1..65535.
- `RX_DELAY_CYCLES`, 0: cycles from the `sync_adc` rising edge to the `start_rx` pulse; range 0..65535.
- `TIMEOUT_CYCLES`, 20000: watchdog length in WAIT_DONE, counted from the `start_rx` cycle; range 2..65535.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: gates trigger acceptance.
- `trigger` in 1: single-cycle request for a conversion.
- `done0`, `done1` in 1: level `adc_uart_done` from receivers 0 and 1. Both are 1 out of reset.
- `sync_adc` out 1: AMDS conversion-start pin.
- `start_rx` out 1: one-cycle pulse, fanned out to both receivers.
- `busy` out 1: high in every state except IDLE.
- `sample_done` out 1: one-cycle pulse at the end of every accepted sequence, including sequences that time out.
- `timed_out` out 1: level; the last sequence ended by the watchdog. Cleared at the next accepted trigger.
- `count_trigger` out 16: accepted triggers; wraps.
- `count_missed` out 16: triggers dropped because the block was busy or disabled; wraps.
- `count_timeout` out 16: watchdog expirations; wraps.

## Operation
- States: IDLE, SYNC_HIGH, WAIT_START, WAIT_DONE.
- IDLE:
  - `trigger & enable`: go to SYNC_HIGH, load the 16-bit phase counter with 0, increment `count_trigger`, clear `timed_out`.
  - `trigger & ~enable`: increment `count_missed`.
- SYNC_HIGH:
  - `sync_adc` = 1. The phase counter counts cycles since entry; on entry it is 0.
  - `start_rx` pulses when the counter equals `RX_DELAY_CYCLES`, provided that value is < `SYNC_HIGH_CYCLES`.
  - When the counter reaches `SYNC_HIGH_CYCLES-1`:
    - If `start_rx` has already pulsed, go to WAIT_DONE.
    - Otherwise go to WAIT_START and keep counting.
- WAIT_START:
  - `sync_adc` = 0.
  - `start_rx` pulses when the counter equals `RX_DELAY_CYCLES`; go to WAIT_DONE on that same cycle.
- WAIT_DONE:
  - The watchdog counter is cleared on the `start_rx` cycle and increments every following cycle.
  - `done0`/`done1` are ignored on the first cycle after `start_rx`. The receivers drop done one cycle after `start_rx`, so a stale 1 would otherwise be seen.
  - From the second cycle onward, `done0 & done1` ends the sequence: pulse `sample_done`, go to IDLE.
  - If the watchdog equals `TIMEOUT_CYCLES-1` and both dones are not yet high: pulse `sample_done`, set `timed_out`, increment `count_timeout`, go to IDLE.
  - If done and watchdog expiry occur on the same cycle, done wins; no timeout is counted.
- `trigger` in any non-IDLE state: increment `count_missed`; the sequence is unaffected.
- `enable` deasserted mid-sequence: the sequence runs to completion.
- Counters saturate nowhere: 0xFFFF+1 → 0x0000.

## Timing
- Reset values: `sync_adc` 0, `start_rx` 0, `busy` 0, `sample_done` 0, `timed_out` 0, all counters 0, state IDLE.
- All outputs are registered, with no combinational path from input to output.
- Trigger to `sync_adc` high: 1 cycle (trigger sampled at edge N, `sync_adc` high after edge N+1).
- `sync_adc` high width is exactly `SYNC_HIGH_CYCLES` cycles.
- `start_rx` is asserted exactly once per accepted trigger, `RX_DELAY_CYCLES` cycles after `sync_adc` rises.
- Earliest next accepted trigger: the cycle in which `sample_done` is high is still busy. A trigger on the following cycle is accepted.
- `rst` mid-sequence:
  - Immediate return to reset values on the next edge; `sync_adc` drops.
  - No `sample_done` pulse is issued and no counter is incremented.

## Structure
- Shared package `amds_pkg` holds:
  - the state encoding localparams;
  - the 16-bit counter width constant `AMDS_CNT_W`;
  - the receiver count `AMDS_N_RX = 2`.
- One sub-module, `amds_wrap_counter`: a 16-bit synchronous-reset counter with an increment input. It is instantiated three times, for the trigger, missed and timeout counters.
- The phase and watchdog counters are inline in the FSM module.

## Test plan
- Nominal run, with `SYNC_HIGH_CYCLES`=4, `RX_DELAY_CYCLES`=0, `TIMEOUT_CYCLES`=50:
  - Stimulus: trigger with `enable`=1; the model drops `done0`/`done1` one cycle after `start_rx` and raises them 10 cycles later.
  - Response: `sync_adc` high for 4 cycles, `start_rx` on the first of them, `sample_done` once, `count_trigger`=1, `timed_out`=0.
- Delayed start, with `RX_DELAY_CYCLES`=6 and `SYNC_HIGH_CYCLES`=4:
  - Stimulus: one accepted trigger.
  - Response: `start_rx` 2 cycles after `sync_adc` falls; `busy` high throughout.
- Timeout:
  - Stimulus: `done1` never returns high.
  - Response: `sample_done` exactly 50 cycles after `start_rx` (`TIMEOUT_CYCLES`=50), `timed_out`=1, `count_timeout`=1.
  - A following good sequence clears `timed_out`.
- Dropped triggers:
  - Stimulus: 3 triggers while busy, plus 2 with `enable`=0.
  - Response: `count_missed`=5, `count_trigger` unchanged, exactly one `start_rx` per accepted trigger.
- Done/timeout collision:
  - Stimulus: both dones rise on the watchdog's last cycle.
  - Response: `sample_done`=1, `timed_out`=0, `count_timeout` unchanged.
- Reset mid-WAIT_DONE:
  - Response: all outputs at reset values the next cycle, no `sample_done`.
- Counter wrap:
  - Stimulus: `count_trigger` preloaded to 0xFFFF via a forced sequence.
  - Response: the next trigger yields 0x0000.
